rtc_bus_scheduler: RTL and testbench
====================================

Name: rtc_bus_scheduler

Overview:
Sequencer and arbiter for the shared RTC multiplexed address/data bus. Owns the phase counter `count` and register index `cuenta_dir` consumed by the RTC read datapath. Grants the bus either to the periodic read sweep (9 timekeeping/timer registers) or to write requests from the configuration logic, and separates transactions with a bus-idle gap.

Parameters:
READ_LEN, 170, cycles per read transaction; `count` runs 0..READ_LEN-1 (max 256).
WRITE_LEN, 170, cycles per write transaction; `count` runs 0..WRITE_LEN-1 (max 256).
GAP_LEN, 8, idle cycles between transactions (min 1).
NUM_REGS, 9, registers per read sweep; `cuenta_dir` wraps at NUM_REGS-1.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  periodic read sweep enable
wr_req  in  1  write request, level; held until wr_ack
wr_addr  in  8  RTC register address for the requested write
wr_ack  out  1  one-cycle grant pulse for wr_req
count  out  8  transaction phase counter to the read/write sequencers
cuenta_dir  out  4  index of register currently being read (0..NUM_REGS-1)
en_lectura  out  1  enable to the read sequencer, high for the whole READ state
en_escritura  out  1  enable to the write sequencer, high for the whole WRITE state
dir_escritura  out  8  latched wr_addr, valid while en_escritura=1
busy  out  1  high in any state other than IDLE
sweep_done  out  1  one-cycle pulse when `cuenta_dir` wraps NUM_REGS-1 -> 0

Behaviour:
- Reset (async, reset=0) values:
  - state=IDLE; count=0, cuenta_dir=0, dir_escritura=0.
  - wr_ack, en_lectura, en_escritura, busy, sweep_done all 0.
  - Internal last_was_write=0.
- States: IDLE, READ, WRITE, GAP (plus INIT, see Optional Feature). `count` is cleared to 0 on every state entry and increments by 1 per clk inside READ/WRITE/GAP.
- IDLE: `count` held at 0. Next-state decision (the same rule applies at the end of GAP):
  - wr_req=1 and last_was_write=0 -> WRITE.
  - else en=1 -> READ.
  - else wr_req=1 -> WRITE.
  - else IDLE.
- Grant to WRITE: wr_ack pulses high for exactly the first WRITE cycle. dir_escritura latches wr_addr on the granting edge. last_was_write is set to 1.
- READ: en_lectura=1. At count==READ_LEN-1:
  - next state is GAP;
  - cuenta_dir increments, wrapping NUM_REGS-1 -> 0;
  - on the wrap, sweep_done is high for the first GAP cycle;
  - last_was_write is cleared to 0.
- WRITE: en_escritura=1. At count==WRITE_LEN-1 -> GAP. cuenta_dir is unchanged.
- GAP: both enables 0. After GAP_LEN cycles (count==GAP_LEN-1), apply the IDLE decision rule. If the rule selects nothing, go to IDLE.
- Fairness: a write has priority over a read. Consecutive writes are allowed only when en=0. With en=1 and wr_req held, the pattern is WRITE, GAP, READ, GAP, WRITE, ...
- en deasserted mid-READ: the transaction completes unaltered; the scheduler stops at the next decision point. A transaction is never aborted except by reset.
- Writes are served independently of en.
- wr_req sampling: wr_req is examined only at decision points. A wr_req that drops before grant is lost without an ack.
- Reset mid-transaction: all outputs return to their reset values immediately (async).
- cuenta_dir values >= NUM_REGS are unreachable. If one is forced, the next increment wraps it to 0.

Optional Feature:
Macro RTC_INIT_EN.
- Defined: the first decision after reset enters state INIT, a WRITE-timed transaction (WRITE_LEN cycles, en_escritura=1) with dir_escritura=8'h02 (status/control init register) and no wr_ack. This happens even if en=0 and wr_req=0. INIT -> GAP, then normal operation. It runs once per reset.
- Not defined: INIT does not exist; the first decision follows the IDLE rule.

Test Plan:
1. Reset low 3 cycles, then high with en=1, wr_req=0 -> en_lectura rises on the first clk, count runs 0..169, cuenta_dir goes 0 -> 1 entering GAP, next READ starts 8 cycles later.
2. en=1 for 9 reads -> sweep_done pulses once, after the read with cuenta_dir=8, and cuenta_dir returns to 0.
3. wr_req=1, wr_addr=8'h21 asserted mid-READ -> read completes, GAP 8 cycles, wr_ack 1 cycle, en_escritura 170 cycles, dir_escritura=8'h21, cuenta_dir unchanged.
4. en=1 and wr_req held high -> the bus alternates WRITE/READ, never two WRITEs back to back. With en=0 and wr_req held, WRITEs repeat separated by 8-cycle GAPs.
5. Drop en at count=50 of a READ -> en_lectura stays high until count=169, then GAP, then IDLE with busy=0.
6. Assert reset at count=100 of a WRITE -> en_escritura, count and busy go to 0 without waiting for clk. With RTC_INIT_EN defined, the first transaction after release is INIT with dir_escritura=8'h02.

Source files
------------

// File: rtl/rtc_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_scheduler
// Purpose  : Arbiter/sequencer for the multiplexed RTC bus. It interleaves the
//            periodic read sweep with write grants and inserts an idle gap
//            between transactions. Optional macro RTC_INIT_EN adds a one-shot
//            INIT write to register 8'h02 after reset.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_scheduler #(
  parameter int READ_LEN  = 170,
  parameter int WRITE_LEN = 170,
  parameter int GAP_LEN   = 8,
  parameter int NUM_REGS  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  output logic       wr_ack,
  output logic [7:0] count,
  output logic [3:0] cuenta_dir,
  output logic       en_lectura,
  output logic       en_escritura,
  output logic [7:0] dir_escritura,
  output logic       busy,
  output logic       sweep_done
);

  localparam logic [7:0] C_READ_LAST  = 8'(READ_LEN - 1);
  localparam logic [7:0] C_WRITE_LAST = 8'(WRITE_LEN - 1);
  localparam logic [7:0] C_GAP_LAST   = 8'(GAP_LEN - 1);
  localparam logic [3:0] C_REG_LAST   = 4'(NUM_REGS - 1);
  localparam logic [7:0] C_INIT_ADDR  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_GAP   = 3'd3,
    S_INIT  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_was_write;
  logic   w_init_pending;
  logic   w_decide;
  logic   w_pick_write;

`ifdef RTC_INIT_EN
  logic r_init_done;

  // The very first decision after reset is always taken from IDLE, so one
  // cycle out of reset is enough to retire the INIT request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_init_done <= 1'b0;
    else        r_init_done <= 1'b1;
  end

  assign w_init_pending = !r_init_done;
`else
  assign w_init_pending = 1'b0;
`endif

  // A write wins unless the previous grant was also a write and reads are enabled.
  always_comb begin
    w_decide     = (r_state == S_IDLE) || ((r_state == S_GAP) && (count == C_GAP_LAST));
    w_pick_write = wr_req && (!r_last_was_write || !en);
    w_next       = S_IDLE;
    if (w_init_pending)    w_next = S_INIT;
    else if (w_pick_write) w_next = S_WRITE;
    else if (en)           w_next = S_READ;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_last_was_write <= 1'b0;
      count            <= 8'd0;
      cuenta_dir       <= 4'd0;
      dir_escritura    <= 8'd0;
      wr_ack           <= 1'b0;
      en_lectura       <= 1'b0;
      en_escritura     <= 1'b0;
      busy             <= 1'b0;
      sweep_done       <= 1'b0;
    end else begin
      wr_ack     <= 1'b0;
      sweep_done <= 1'b0;
      if (w_decide) begin
        r_state      <= w_next;
        count        <= 8'd0;
        busy         <= (w_next != S_IDLE);
        en_lectura   <= (w_next == S_READ);
        en_escritura <= (w_next == S_WRITE) || (w_next == S_INIT);
        if (w_next == S_WRITE) begin
          wr_ack           <= 1'b1;
          dir_escritura    <= wr_addr;
          r_last_was_write <= 1'b1;
        end
        if (w_next == S_INIT) begin
          dir_escritura <= C_INIT_ADDR;
        end
      end else begin
        case (r_state)
          S_READ: begin
            if (count == C_READ_LAST) begin
              r_state          <= S_GAP;
              count            <= 8'd0;
              en_lectura       <= 1'b0;
              r_last_was_write <= 1'b0;
              // Any out-of-range index also folds back to 0 here.
              if (cuenta_dir >= C_REG_LAST) begin
                cuenta_dir <= 4'd0;
                sweep_done <= 1'b1;
              end else begin
                cuenta_dir <= cuenta_dir + 4'd1;
              end
            end else begin
              count <= count + 8'd1;
            end
          end
          S_WRITE, S_INIT: begin
            if (count == C_WRITE_LAST) begin
              r_state      <= S_GAP;
              count        <= 8'd0;
              en_escritura <= 1'b0;
            end else begin
              count <= count + 8'd1;
            end
          end
          S_GAP: begin
            count <= count + 8'd1;
          end
          default: begin
            r_state      <= S_IDLE;
            count        <= 8'd0;
            en_lectura   <= 1'b0;
            en_escritura <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_bus_scheduler
// Purpose  : Scoreboard bench for rtc_bus_scheduler: stimulus queues expected
//            bus transactions, a negedge monitor reconstructs and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = 8'd0;
  logic       wr_ack;
  logic [7:0] count;
  logic [3:0] cuenta_dir;
  logic       en_lectura;
  logic       en_escritura;
  logic [7:0] dir_escritura;
  logic       busy;
  logic       sweep_done;

  rtc_bus_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_ack       (wr_ack),
    .count        (count),
    .cuenta_dir   (cuenta_dir),
    .en_lectura   (en_lectura),
    .en_escritura (en_escritura),
    .dir_escritura(dir_escritura),
    .busy         (busy),
    .sweep_done   (sweep_done)
  );

  always #5 clk = ~clk;

  // kind: 0 = read, 1 = write-timed (write or INIT); gap < 0 means not checked
  typedef struct {
    int kind;
    int len;
    int idx;
    int dir;
    int ack;
    int sweep;
    int gap;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=no_event required=event (t=%0t)", name, $time);
  endtask

  task automatic push(input int kind, input int len, input int idx, input int dir,
                      input int ack, input int sweep, input int gap);
    txn_t t;
    t.kind = kind; t.len = len; t.idx = idx; t.dir = dir;
    t.ack = ack; t.sweep = sweep; t.gap = gap;
    sb.push_back(t);
  endtask

  task automatic compare(input txn_t o);
    txn_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_txn actual=kind%0d_idx%0d_dir%0h required=none (t=%0t)",
               o.kind, o.idx, o.dir, $time);
      return;
    end
    e = sb.pop_front();
    chk("txn_kind", o.kind, e.kind);
    chk("txn_len", o.len, e.len);
    chk("txn_idx", o.idx, e.idx);
    chk("txn_ack", o.ack, e.ack);
    chk("txn_sweep", o.sweep, e.sweep);
    if (e.kind == 1) chk("txn_dir", o.dir, e.dir);
    if (e.gap >= 0)  chk("txn_gap", o.gap, e.gap);
  endtask

  // Monitor: rebuilds each transaction from the enables, compares when it ends
  bit   in_txn = 1'b0;
  int   idle_cnt = 0;
  txn_t cur;

  always @(negedge clk) begin
    if (en_lectura && en_escritura) chk("enables_exclusive", 32'd1, 32'd0);
    if (en_lectura || en_escritura) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        cur.kind = en_lectura ? 0 : 1;
        cur.len  = 1;
        cur.idx  = int'(cuenta_dir);
        cur.dir  = int'(dir_escritura);
        cur.ack  = int'(wr_ack);
        cur.gap  = idle_cnt;
      end else begin
        cur.len++;
        if (wr_ack) chk("ack_width", wr_ack, 32'd0);
      end
    end else if (in_txn) begin
      in_txn    = 1'b0;
      cur.sweep = int'(sweep_done);
      idle_cnt  = 1;
      compare(cur);
    end else begin
      idle_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read_at(input int idx, input int cnt, input string name);
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (en_lectura && int'(cuenta_dir) == idx && int'(count) == cnt) return;
    end
    timeout(name);
  endtask

  task automatic wait_write_at(input int cnt, input string name);
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (en_escritura && int'(count) == cnt) return;
    end
    timeout(name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (sb.size() == 0) break;
    end
    chk(name, sb.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acks;

    // Reset values
    repeat (3) cyc();
    chk("rst_count", count, 32'd0);
    chk("rst_cuenta_dir", cuenta_dir, 32'd0);
    chk("rst_dir", dir_escritura, 32'd0);
    chk("rst_ack", wr_ack, 32'd0);
    chk("rst_en_lectura", en_lectura, 32'd0);
    chk("rst_en_escritura", en_escritura, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_sweep", sweep_done, 32'd0);

    // Full sweep of 9 reads
`ifdef RTC_INIT_EN
    push(1, 170, 0, 8'h02, 0, 0, -1);
    push(0, 170, 0, 0, 0, 0, 8);
`else
    push(0, 170, 0, 0, 0, 0, -1);
`endif
    for (int i = 1; i < 9; i++) push(0, 170, i, 0, 0, (i == 8) ? 1 : 0, 8);
    en    = 1'b1;
    reset = 1'b1;
    cyc();
`ifdef RTC_INIT_EN
    chk("first_init_en", en_escritura, 32'd1);
    chk("first_init_dir", dir_escritura, 32'h02);
    chk("first_init_ack", wr_ack, 32'd0);
`else
    chk("first_read_en", en_lectura, 32'd1);
    chk("first_read_count", count, 32'd0);
    chk("first_read_busy", busy, 32'd1);
`endif
    drain("sweep_drain");
    chk("cuenta_dir_wrap", cuenta_dir, 32'd0);

    // Write requested mid-read, then held with en=1: strict alternation
    push(0, 170, 0, 0, 0, 0, 8);
    wait_read_at(0, 20, "wait_read0");
    wr_addr = 8'h21;
    wr_req  = 1'b1;
    push(1, 170, 1, 8'h21, 1, 0, 8);
    push(0, 170, 1, 0, 0, 0, 8);
    push(1, 170, 2, 8'h21, 1, 0, 8);
    push(0, 170, 2, 0, 0, 0, 8);

    // en dropped mid-read with wr_req held: read completes, then writes repeat
    wait_read_at(2, 50, "wait_read2");
    en = 1'b0;
    push(1, 170, 3, 8'h21, 1, 0, 8);
    push(1, 170, 3, 8'h21, 1, 0, 8);
    acks = 0;
    for (int i = 0; i < 4000 && acks < 2; i++) begin
      cyc();
      if (wr_ack) acks++;
    end
    if (acks < 2) timeout("wait_two_acks");
    wr_req = 1'b0;
    drain("alt_drain");
    repeat (12) cyc();
    chk("idle_busy", busy, 32'd0);
    chk("idle_count", count, 32'd0);
    chk("idle_en_escritura", en_escritura, 32'd0);
    chk("idle_cuenta_dir", cuenta_dir, 32'd3);
    chk("idle_dir_held", dir_escritura, 32'h21);

    // Single read stopped by en drop; a short wr_req pulse mid-read is lost
    en = 1'b1;
    push(0, 170, 3, 0, 0, 0, -1);
    wait_read_at(3, 50, "wait_read3_50");
    en = 1'b0;
    wait_read_at(3, 60, "wait_read3_60");
    wr_addr = 8'h77;
    wr_req  = 1'b1;
    cyc();
    wr_req = 1'b0;
    drain("stop_drain");
    repeat (12) cyc();
    chk("stop_busy", busy, 32'd0);
    chk("stop_en_lectura", en_lectura, 32'd0);
    chk("stop_cuenta_dir", cuenta_dir, 32'd4);
    chk("lost_req_dir", dir_escritura, 32'h21);

    // Asynchronous reset in the middle of a write
    wr_addr = 8'h5A;
    wr_req  = 1'b1;
    push(1, 101, 4, 8'h5A, 1, 0, -1);
    wait_write_at(100, "wait_write100");
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_en_escritura", en_escritura, 32'd0);
    chk("arst_count", count, 32'd0);
    chk("arst_busy", busy, 32'd0);
    chk("arst_dir", dir_escritura, 32'd0);
    chk("arst_cuenta_dir", cuenta_dir, 32'd0);
    wr_req = 1'b0;
    repeat (2) cyc();
`ifdef RTC_INIT_EN
    push(1, 170, 0, 8'h02, 0, 0, -1);
`endif
    reset = 1'b1;
    repeat (5) cyc();
`ifndef RTC_INIT_EN
    chk("post_rst_busy", busy, 32'd0);
`endif
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
